// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin snooping bus controller with backing memory.
// Ports: clock/clear, per-CPU req_*, grant, bus_* broadcast, snp_* replies, resp_* completion.
module snoop_bus_ctrl #(
  parameter int NCPU      = 3,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 3,
  parameter int SNOOP_LAT = 2
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NCPU-1:0]          req_valid,
  input  logic [2*NCPU-1:0]        req_op,
  input  logic [NCPU*TAG_W-1:0]    req_tag,
  output logic [NCPU-1:0]          grant,
  output logic                     bus_valid,
  output logic [1:0]               bus_op,
  output logic [TAG_W-1:0]         bus_tag,
  output logic [$clog2(NCPU)-1:0]  bus_src,
  input  logic [NCPU-1:0]          snp_shared,
  input  logic [NCPU-1:0]          snp_flush,
  input  logic [NCPU*DATA_W-1:0]   snp_data,
  output logic [NCPU-1:0]          resp_done,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_shared
);

  localparam int SW    = $clog2(NCPU);
  localparam int CW    = $clog2(SNOOP_LAT + 1);
  localparam int DEPTH = 2 ** TAG_W;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BCAST = 3'd1;
  localparam logic [2:0] SNOOP = 3'd2;
  localparam logic [2:0] WB    = 3'd3;
  localparam logic [2:0] MEM   = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     src_q;
  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [SW-1:0]     rr_ptr;
  logic              shr_q;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              found;
  logic [SW-1:0]     pick;
  logic [1:0]        pick_op;
  logic [TAG_W-1:0]  pick_tag;
  int                k;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pick_op  = '0;
    pick_tag = '0;
    k        = 0;
    for (int i = 0; i < NCPU; i++) begin
      k = (int'(rr_ptr) + i) % NCPU;
      if (!found && req_valid[k]) begin
        found    = 1'b1;
        pick     = SW'(k);
        pick_op  = req_op[2*k +: 2];
        pick_tag = req_tag[TAG_W*k +: TAG_W];
      end
    end
  end

  // grant is one-hot on the requester, so it doubles as the self-snoop mask
  logic [NCPU-1:0]   shr_m;
  logic [NCPU-1:0]   fl_m;
  logic [DATA_W-1:0] fl_data;

  assign shr_m = snp_shared & ~grant;
  assign fl_m  = snp_flush & ~grant;

  // descending scan leaves the lowest-index flusher's data
  always_comb begin
    fl_data = '0;
    for (int i = NCPU - 1; i >= 0; i--) begin
      if (fl_m[i]) fl_data = snp_data[DATA_W*i +: DATA_W];
    end
  end

  assign bus_valid = (state == BCAST);
  assign bus_op    = bus_valid ? op_q  : '0;
  assign bus_tag   = bus_valid ? tag_q : '0;
  assign bus_src   = bus_valid ? src_q : '0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      cnt         <= '0;
      src_q       <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      grant       <= '0;
      rr_ptr      <= '0;
      shr_q       <= 1'b0;
      wb_data     <= '0;
      rdata       <= '0;
      resp_done   <= '0;
      resp_data   <= '0;
      resp_shared <= 1'b0;
    end else begin
      resp_done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            src_q <= pick;
            op_q  <= pick_op;
            tag_q <= pick_tag;
            grant <= NCPU'(1) << pick;
            state <= BCAST;
          end
        end
        BCAST: begin
          cnt   <= '0;
          state <= SNOOP;
        end
        SNOOP: begin
          if (cnt == CW'(SNOOP_LAT - 1)) begin
            shr_q <= |(shr_m | fl_m);
            if (|fl_m) begin
              wb_data <= fl_data;
              state   <= WB;
            end else if (op_q[1] ^ op_q[0]) begin
              state <= MEM;
            end else begin
              rdata <= '0;
              state <= RESP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          rdata <= wb_data;
          state <= RESP;
        end
        MEM: begin
          rdata <= mem[tag_q];
          state <= RESP;
        end
        RESP: begin
          // completion is registered, so the done pulse lands in the next IDLE cycle
          resp_done   <= grant;
          resp_data   <= rdata;
          resp_shared <= shr_q;
          grant       <= '0;
          rr_ptr      <= (src_q == SW'(NCPU - 1)) ? '0 : src_q + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (state == WB) begin
      mem[tag_q] <= wb_data;
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: scenario tasks for snoop_bus_ctrl (NCPU=3, TAG_W=3, DATA_W=3, SNOOP_LAT=2).
// Expected completions are queued when a request is driven and popped on resp_done.
module tb_snoop_bus_ctrl;

  logic       clock;
  logic       clear;
  logic [2:0] req_valid;
  logic [5:0] req_op;
  logic [8:0] req_tag;
  logic [2:0] grant;
  logic       bus_valid;
  logic [1:0] bus_op;
  logic [2:0] bus_tag;
  logic [1:0] bus_src;
  logic [2:0] snp_shared;
  logic [2:0] snp_flush;
  logic [8:0] snp_data;
  logic [2:0] resp_done;
  logic [2:0] resp_data;
  logic       resp_shared;

  snoop_bus_ctrl #(
    .NCPU(3), .TAG_W(3), .DATA_W(3), .SNOOP_LAT(2)
  ) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_op(req_op), .req_tag(req_tag),
    .grant(grant),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_tag(bus_tag), .bus_src(bus_src),
    .snp_shared(snp_shared), .snp_flush(snp_flush), .snp_data(snp_data),
    .resp_done(resp_done), .resp_data(resp_data), .resp_shared(resp_shared)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] done;
    logic [2:0] data;
    logic       shared;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [2:0] mem_m [8];
  int         checks = 0;
  int         errors = 0;

  always @(negedge clock) begin
    if (clear && resp_done != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got %b want none", resp_done);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (resp_done !== mon_e.done) begin
          errors++;
          $display("FAIL done_vec got %b want %b", resp_done, mon_e.done);
        end
        checks++;
        if (resp_data !== mon_e.data) begin
          errors++;
          $display("FAIL resp_data got %0d want %0d", resp_data, mon_e.data);
        end
        checks++;
        if (resp_shared !== mon_e.shared) begin
          errors++;
          $display("FAIL resp_shared got %b want %b", resp_shared, mon_e.shared);
        end
      end
    end
  end

  task automatic issue(input int cpu, input logic [1:0] op, input logic [2:0] tag,
                       input logic [2:0] shr, input logic [2:0] fl, input logic [8:0] dat,
                       output int lat, output int bvn, output logic [1:0] bop,
                       output logic [2:0] btag, output logic [1:0] bsrc);
    logic [2:0] m;
    logic [2:0] ed;
    logic [2:0] one;
    exp_t       e;
    int         f;
    bit         seen;
    one = 3'b001;
    m   = ~(one << cpu);
    f   = -1;
    for (int i = 2; i >= 0; i--) if (fl[i] && m[i]) f = i;
    if (f >= 0) begin
      ed         = dat[f*3 +: 3];
      mem_m[tag] = ed;
    end else if (op == 2'b01 || op == 2'b10) begin
      ed = mem_m[tag];
    end else begin
      ed = 3'd0;
    end
    e.done   = one << cpu;
    e.data   = ed;
    e.shared = |((shr | fl) & m);
    exp_q.push_back(e);
    @(negedge clock);
    req_valid[cpu]       = 1'b1;
    req_op[cpu*2 +: 2]   = op;
    req_tag[cpu*3 +: 3]  = tag;
    snp_shared           = shr;
    snp_flush            = fl;
    snp_data             = dat;
    lat  = 0;
    bvn  = 0;
    bop  = 2'b00;
    btag = 3'd0;
    bsrc = 2'd0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (bus_valid) begin
        bvn++;
        bop  = bus_op;
        btag = bus_tag;
        bsrc = bus_src;
      end
      if (resp_done[cpu]) seen = 1'b1;
    end
    req_valid[cpu] = 1'b0;
    snp_shared     = 3'b000;
    snp_flush      = 3'b000;
    snp_data       = 9'd0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout cpu %0d got none want done within 40", cpu);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic test_reset();
    req_valid  = 3'b000;
    req_op     = 6'd0;
    req_tag    = 9'd0;
    snp_shared = 3'b000;
    snp_flush  = 3'b000;
    snp_data   = 9'd0;
    clear      = 1'b0;
    for (int i = 0; i < 8; i++) mem_m[i] = 3'(i);
    repeat (2) @(negedge clock);
    checks++;
    if ({grant, bus_valid, resp_done, resp_data, resp_shared} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {grant, bus_valid, resp_done, resp_data, resp_shared});
    end
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read();
    int lat, bvn;
    logic [1:0] bop, bsrc;
    logic [2:0] btag;
    issue(0, 2'b01, 3'd5, 3'b000, 3'b000, 9'd0, lat, bvn, bop, btag, bsrc);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL read_latency got %0d want 6", lat);
    end
    checks++;
    if (bvn !== 1 || bop !== 2'b01 || btag !== 3'd5 || bsrc !== 2'd0) begin
      errors++;
      $display("FAIL read_bcast got n%0d op%b tag%0d src%0d want n1 op01 tag5 src0",
               bvn, bop, btag, bsrc);
    end
  endtask

  task automatic test_flush();
    int lat, bvn;
    logic [1:0] bop, bsrc;
    logic [2:0] btag;
    issue(1, 2'b01, 3'd2, 3'b000, 3'b100, {3'd6, 3'd0, 3'd0}, lat, bvn, bop, btag, bsrc);
    checks++;
    if (lat !== 6 || bsrc !== 2'd1) begin
      errors++;
      $display("FAIL flush_latency got %0d src %0d want 6 src 1", lat, bsrc);
    end
    issue(0, 2'b01, 3'd2, 3'b000, 3'b000, 9'd0, lat, bvn, bop, btag, bsrc);
  endtask

  task automatic test_invalidate();
    int lat, bvn;
    logic [1:0] bop, bsrc;
    logic [2:0] btag;
    issue(2, 2'b11, 3'd1, 3'b001, 3'b000, 9'd0, lat, bvn, bop, btag, bsrc);
    checks++;
    if (lat !== 5 || bop !== 2'b11) begin
      errors++;
      $display("FAIL inval_latency got %0d op %b want 5 op 11", lat, bop);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [2:0] g;
    exp_t       e;
    int         src, prev, t;
    bit         ok;
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001};
    prev    = -1;
    @(negedge clock);
    req_op    = {2'b01, 2'b01, 2'b01};
    req_tag   = {3'd3, 3'd2, 3'd1};
    req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      g  = 3'b000;
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 20) begin
        @(negedge clock);
        t++;
        if (prev >= 0) begin
          req_valid[prev] = 1'b1;
          prev = -1;
        end
        if (grant != 3'b000) begin
          g  = grant;
          ok = 1'b1;
        end
      end
      checks++;
      if (g !== exp_g[n]) begin
        errors++;
        $display("FAIL rr_grant_%0d got %b want %b", n, g, exp_g[n]);
      end
      src = 0;
      for (int i = 0; i < 3; i++) if (g[i]) src = i;
      e.done   = g;
      e.data   = mem_m[req_tag[src*3 +: 3]];
      e.shared = 1'b0;
      if (ok) exp_q.push_back(e);
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 20) begin
        @(negedge clock);
        t++;
        if (resp_done != 3'b000) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_done_timeout_%0d got none want done", n);
      end
      req_valid[src] = 1'b0;
      prev = src;
    end
    req_valid = 3'b000;
    @(negedge clock);
  endtask

  task automatic test_shared_own();
    int lat, bvn;
    logic [1:0] bop, bsrc;
    logic [2:0] btag;
    issue(0, 2'b01, 3'd3, 3'b001, 3'b000, 9'd0, lat, bvn, bop, btag, bsrc);
  endtask

  task automatic test_multi_flush();
    int lat, bvn;
    logic [1:0] bop, bsrc;
    logic [2:0] btag;
    issue(0, 2'b10, 3'd4, 3'b000, 3'b110, {3'd7, 3'd3, 3'd0}, lat, bvn, bop, btag, bsrc);
    checks++;
    if (bop !== 2'b10 || btag !== 3'd4) begin
      errors++;
      $display("FAIL wmiss_bcast got op%b tag%0d want op10 tag4", bop, btag);
    end
    issue(2, 2'b01, 3'd4, 3'b000, 3'b000, 9'd0, lat, bvn, bop, btag, bsrc);
  endtask

  task automatic test_clear_mid();
    int lat, bvn;
    logic [1:0] bop, bsrc;
    logic [2:0] btag;
    @(negedge clock);
    req_valid[1]  = 1'b1;
    req_op[3:2]   = 2'b01;
    req_tag[5:3]  = 3'd2;
    snp_flush     = 3'b100;
    snp_data      = {3'd1, 3'd0, 3'd0};
    repeat (3) @(negedge clock);
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL mid_grant got %b want 010", grant);
    end
    #2 clear = 1'b0;
    #1;
    checks++;
    if ({grant, bus_valid, resp_done, resp_data, resp_shared} !== 11'd0) begin
      errors++;
      $display("FAIL mid_clear_outputs got %b want 0",
               {grant, bus_valid, resp_done, resp_data, resp_shared});
    end
    req_valid = 3'b000;
    snp_flush = 3'b000;
    snp_data  = 9'd0;
    for (int i = 0; i < 8; i++) mem_m[i] = 3'(i);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    repeat (2) @(negedge clock);
    issue(0, 2'b01, 3'd2, 3'b000, 3'b000, 9'd0, lat, bvn, bop, btag, bsrc);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL post_clear_latency got %0d want 6", lat);
    end
    issue(2, 2'b01, 3'd4, 3'b000, 3'b000, 9'd0, lat, bvn, bop, btag, bsrc);
  endtask

  initial begin
    clear = 1'b0;
    test_reset();
    test_read();
    test_flush();
    test_invalidate();
    test_round_robin();
    test_shared_own();
    test_multi_flush();
    test_clear_mid();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_bus_ctrl.md
SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

Interface
REQ-001 SHALL have parameter NCPU, default 3: number of snooping caches (2..8).
REQ-002 SHALL have parameter TAG_W, default 3: block tag width; memory depth is 2**TAG_W.
REQ-003 SHALL have parameter DATA_W, default 3: block data width.
REQ-004 SHALL have parameter SNOOP_LAT, default 2: snoop window in cycles (>=1).
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port clear, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, NCPU: per-CPU bus request, held until that CPU's resp_done.
REQ-008 SHALL have port req_op, input, 2*NCPU: per-CPU op; 01 read miss, 10 write miss, 11 invalidate, 00 no-op.
REQ-009 SHALL have port req_tag, input, NCPU*TAG_W: per-CPU tag.
REQ-010 SHALL have port grant, output, NCPU: one-hot owner of the current transaction.
REQ-011 SHALL have ports bus_valid (output, 1), bus_op (output, 2), bus_tag (output, TAG_W) and bus_src (output, clog2(NCPU)): broadcast message.
REQ-012 SHALL have ports snp_shared (input, NCPU), snp_flush (input, NCPU) and snp_data (input, NCPU*DATA_W): snoop replies.
REQ-013 SHALL have ports resp_done (output, NCPU, one-hot pulse), resp_data (output, DATA_W) and resp_shared (output, 1): completion.

Function
REQ-014 SHALL implement FSM IDLE, BCAST, SNOOP, WB, MEM, RESP.
REQ-015 IDLE: when any req_valid is 1, pick the first set bit at or after rr_ptr (wrapping); latch src, op and tag; set grant; go to BCAST.
REQ-016 BCAST: bus_valid=1 for exactly one cycle with latched op/tag/src; go to SNOOP.
REQ-017 SNOOP: stay SNOOP_LAT cycles; sample snp_* on the last cycle, masking out the requester's own bit.
REQ-018 The bus shall compute resp_shared as the OR of masked snp_shared and masked snp_flush.
REQ-019 Leaving SNOOP: a masked flush goes to WB; otherwise op 01/10 goes to MEM and op 11/00 goes to RESP with resp_data=0.
REQ-020 WB: write mem[tag] with the flush data of the lowest-index flushing CPU; resp_data = that data; go to RESP.
REQ-021 MEM: resp_data = mem[tag]; go to RESP.
REQ-022 RESP: resp_done[src]=1 for one cycle; grant clears on exit; rr_ptr = (src+1) mod NCPU; go to IDLE.
REQ-023 Latency: with the request accepted at edge E0, resp_done shall be high in the cycle after edge E(SNOOP_LAT+3) for all ops; with no flush, op 11/00 shall complete one cycle earlier.
REQ-024 resp_data and resp_shared shall hold their values from RESP until the next RESP.
REQ-025 A req_valid still high in the IDLE cycle after RESP shall be a new request, arbitrated normally.
REQ-026 req_* changes during a transaction shall be ignored; only one transaction shall be in flight.

Reset
REQ-027 clear=0 shall immediately force state IDLE, rr_ptr=0, and grant, bus_*, resp_done, resp_data and resp_shared to 0.
REQ-028 clear=0 shall set mem[i] = i mod 2**DATA_W; an in-flight transaction is dropped with no resp_done and no memory write.

Verification (NCPU=3, TAG_W=3, DATA_W=3, SNOOP_LAT=2)
REQ-029 Bench: release clear; CPU0 reads tag 5 with no snoop -> bus_valid one cycle (op 01, tag 5, src 0); resp_done=001 in the cycle after E5; resp_data=5; resp_shared=0.
REQ-030 Bench: CPU1 reads tag 2; CPU2 replies flush with data 6 -> mem[2]=6, resp_data=6, resp_shared=1; a later CPU0 read of tag 2 with no snoop returns 6.
REQ-031 Bench: req_valid=111 held, each requester dropping after its done then reasserting -> grant order 001, 010, 100, 001.
REQ-032 Bench: CPU0 reads tag 3 with snp_shared=001 -> resp_shared=0, resp_data=3.
REQ-033 Bench: CPU0 write miss tag 4; CPU1 and CPU2 flush with data 3 and 7 -> resp_data=3, mem[4]=3.
REQ-034 Bench: clear=0 during SNOOP after a prior WB -> outputs 0 at once, no resp_done, memory back to mem[i]=i; the next request completes normally.
